// File: rtl/ttl_dff_bank.sv
// ttl_dff_bank: WIDTH 74ALS74-style DFFs on clk/reset; ck rise enables capture of d, sn/rn active-low preset/clear, q/qn after inertial DLY_CK/DLY_SR clk delays; DFF_BANK_SYNC_EN adds a 2-flop sync on ck/sn/rn
module ttl_dff_bank #(
  parameter int WIDTH = 8,
  parameter int DLY_CK = 2,
  parameter int DLY_SR = 1,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ck,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] sn,
  input  logic [WIDTH-1:0] rn,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);
  localparam logic [3:0] LD_CK = 4'(DLY_CK - 1);
  localparam logic [3:0] LD_SR = 4'(DLY_SR - 1);
  logic ck_u, ck_d, rise;
  logic [WIDTH-1:0] sn_u, rn_u;
`ifdef DFF_BANK_SYNC_EN
  logic ck_s1, ck_s2;
  logic [WIDTH-1:0] sn_s1, sn_s2, rn_s1, rn_s2;
  always_ff @(posedge clk)
    if (reset) begin
      {ck_s1, ck_s2} <= 2'b11;
      {sn_s1, sn_s2, rn_s1, rn_s2} <= '1;
    end else begin
      {ck_s1, ck_s2} <= {ck, ck_s1};
      {sn_s1, sn_s2} <= {sn, sn_s1};
      {rn_s1, rn_s2} <= {rn, rn_s1};
    end
  assign ck_u = ck_s2;
  assign sn_u = sn_s2;
  assign rn_u = rn_s2;
`else
  assign ck_u = ck;
  assign sn_u = sn;
  assign rn_u = rn;
`endif
  always_ff @(posedge clk) ck_d <= reset ? 1'b1 : ck_u;
  assign rise = ck_u & ~ck_d;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic qb, qnb, pb, pnb, pend, src_ck;
    logic [3:0] cnt;
    logic live, eq, eqn, rq, rqn, tq, tqn, tck;
    // eq/eqn is the output pair after this edge (a due pending change lands now);
    // rq/rqn is what a new target is compared against.
    // A released SR that never landed falls back to the output, so short pulses vanish.
    always_comb begin
      live = pend & (cnt != 4'd0);
      eq   = (pend & ~live) ? pb : qb;
      eqn  = (pend & ~live) ? pnb : qnb;
      rq   = live ? pb : eq;
      rqn  = live ? pnb : eqn;
      tck  = sn_u[i] & rn_u[i] & rise;
      tq   = ~sn_u[i] ? 1'b1 : ~rn_u[i] ? 1'b0 : rise ? d[i] : (live & src_ck) ? pb : eq;
      tqn  = ~rn_u[i] ? 1'b1 : ~sn_u[i] ? 1'b0 : rise ? ~d[i] : (live & src_ck) ? pnb : (eq & eqn) ? 1'b0 : eqn;
    end
    always_ff @(posedge clk)
      if (reset) begin
        qb <= INIT[i];
        qnb <= ~INIT[i];
        pb <= 1'b0;
        pnb <= 1'b0;
        pend <= 1'b0;
        src_ck <= 1'b0;
        cnt <= 4'd0;
      end else begin
        qb <= eq;
        qnb <= eqn;
        if ({tq, tqn} != {rq, rqn}) begin
          if ({tq, tqn} == {eq, eqn}) pend <= 1'b0;
          else begin
            pend <= 1'b1;
            pb <= tq;
            pnb <= tqn;
            src_ck <= tck;
            cnt <= tck ? LD_CK : LD_SR;
          end
        end else if (live) cnt <= cnt - 4'd1;
        else pend <= 1'b0;
      end
    assign q[i] = qb;
    assign qn[i] = qnb;
  end
endmodule

// File: tb/tb_ttl_dff_bank.sv
// tb_ttl_dff_bank: scoreboarded directed checks of two ttl_dff_bank instances (DLY_SR 1 and 4)
module tb_ttl_dff_bank;
`ifdef DFF_BANK_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  logic clk, reset, ck;
  logic [7:0] d, sn, rn, sn_b, rn_b, qa, qna, qb, qnb;
  int cyc = 0, compared = 0, mism = 0;
  typedef struct { int e; bit b; logic [7:0] q; logic [7:0] qn; string n; } exp_t;
  exp_t sb[$];
  logic [7:0] aq, aqn;

  ttl_dff_bank #(.WIDTH(8), .DLY_CK(2), .DLY_SR(1), .INIT(8'h5A)) u_a (
    .clk(clk), .reset(reset), .ck(ck), .d(d), .sn(sn), .rn(rn), .q(qa), .qn(qna));
  ttl_dff_bank #(.WIDTH(8), .DLY_CK(2), .DLY_SR(4), .INIT(8'h04)) u_b (
    .clk(clk), .reset(reset), .ck(ck), .d(d), .sn(sn_b), .rn(rn_b), .q(qb), .qn(qnb));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].e <= cyc) begin
        aq = sb[i].b ? qb : qa;
        aqn = sb[i].b ? qnb : qna;
        compared++;
        if (sb[i].e != cyc || aq !== sb[i].q || aqn !== sb[i].qn) begin
          mism++;
          $display("FAIL %s edge %0d (at %0d): got q=%h qn=%h, want q=%h qn=%h",
                   sb[i].n, sb[i].e, cyc, aq, aqn, sb[i].q, sb[i].qn);
        end
        sb.delete(i);
      end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(int k, bit b, logic [7:0] eq, logic [7:0] eqn, string n);
    sb.push_back('{cyc + k, b, eq, eqn, n});
  endtask

  initial begin
    reset = 1; ck = 1; d = 8'h00; sn = 8'hFF; rn = 8'hFF; sn_b = 8'hFF; rn_b = 8'hFF;
    tick(3);
    reset = 0;
    push_exp(0, 0, 8'h5A, 8'hA5, "rst_a");
    push_exp(0, 1, 8'h04, 8'hFB, "rst_b");
    push_exp(20, 0, 8'h5A, 8'hA5, "rst_hold_a");
    tick(2);
    for (int k = 1; k <= 8 + S; k++) push_exp(k, 1, 8'h04, 8'hFB, "swallow");
    rn_b = 8'hFB;
    tick(2);
    rn_b = 8'hFF;
    tick(6 + S);
    push_exp(4 + S, 1, 8'h04, 8'hFB, "hold_pre");
    push_exp(5 + S, 1, 8'h00, 8'hFF, "hold_fall");
    push_exp(9 + S, 1, 8'h00, 8'hFF, "hold_after");
    rn_b = 8'hFB;
    tick(4);
    rn_b = 8'hFF;
    tick(8 + S);
    ck = 0; d = 8'h3C;
    tick(1);
    ck = 1;
    push_exp(2 + S, 0, 8'h5A, 8'hA5, "ck_early");
    push_exp(3 + S, 0, 8'h3C, 8'hC3, "ck_cap");
    push_exp(3 + S, 1, 8'h3C, 8'hC3, "ck_cap_b");
    tick(3);
    ck = 0;
    tick(4 + S);
    sn = 8'hFE;
    push_exp(1 + S, 0, 8'h3C, 8'hC3, "pre_early");
    push_exp(2 + S, 0, 8'h3D, 8'hC2, "preset");
    tick(3 + S);
    rn = 8'hFE;
    push_exp(2 + S, 0, 8'h3D, 8'hC3, "both_low");
    tick(3 + S);
    sn = 8'hFF; rn = 8'hFF;
    push_exp(1 + S, 0, 8'h3D, 8'hC3, "rel_early");
    push_exp(2 + S, 0, 8'h3D, 8'hC2, "release");
    push_exp(6 + S, 0, 8'h3D, 8'hC2, "rel_hold");
    tick(7 + S);
    sn = 8'hF7; d = 8'h00; ck = 0;
    tick(1);
    ck = 1;
    push_exp(3 + S, 0, 8'h08, 8'hF7, "sr_prio");
    push_exp(3 + S, 1, 8'h00, 8'hFF, "cap_b2");
    tick(3);
    ck = 0;
    tick(6 + S);
    foreach (sb[i]) begin
      mism++;
      $display("FAIL %s edge %0d never checked: got nothing, want q=%h qn=%h", sb[i].n, sb[i].e, sb[i].q, sb[i].qn);
    end
    if (sb.size() != 0) begin
      mism++;
      $display("FAIL scoreboard not empty: %0d left", sb.size());
    end
    if (compared != 25 + S) begin
      mism++;
      $display("FAIL compared %0d, want %0d", compared, 25 + S);
    end
    if (qa !== 8'h08 || qna !== 8'hF7) begin
      mism++;
      $display("FAIL final: got q=%h qn=%h, want q=08 qn=F7", qa, qna);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
